// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU blocks.
// Used by the ALU and the format converter.
package fpu_pkg;

  localparam logic [7:0]  EXP_BIAS      = 8'd127;
  localparam logic [7:0]  EXP_MAX       = 8'd255;
  localparam logic [7:0]  I2F_EXP_INIT  = 8'd158;
  localparam logic [7:0]  F2I_ALIGN_EXP = 8'd150;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;
  localparam logic [31:0] INT_MAX       = 32'h7FFF_FFFF;
  localparam logic [31:0] F_INT_MIN     = 32'hCF00_0000;

  localparam logic OP_I2F = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    ALIGN,
    NEG,
    DONE
  } conv_state_t;

endpackage

// File: rtl/fpu_convert_if.sv
// Operand/result handshake bundle for the converter.
// Valid/ready on both the operand and the result side.
interface fpu_convert_if;

  logic        in_valid;
  logic        in_ready;
  logic        opcode;
  logic [31:0] A;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] O;
  logic        invalid;

  modport slave (
    input  in_valid, opcode, A, out_ready,
    output in_ready, out_valid, O, invalid
  );

  modport master (
    output in_valid, opcode, A, out_ready,
    input  in_ready, out_valid, O, invalid
  );

endinterface

// File: rtl/fpu_round_pack.sv
// Round-to-nearest-even and pack of a normalised magnitude.
// mag[31] is the implicit leading one.
module fpu_round_pack (
  input  logic        sign,
  input  logic [7:0]  exp_in,
  input  logic [31:0] mag,
  output logic [31:0] res
);

  logic        inc;
  logic [23:0] sum;
  logic        unused_bits;

  assign inc = mag[7] & ((|mag[6:0]) | mag[8]);
  assign sum = {1'b0, mag[30:8]} + {23'b0, inc};
  // A carry out of the fraction leaves sum[22:0] already zero.
  assign res = {sign, exp_in + {7'b0, sum[23]}, sum[22:0]};
  assign unused_bits = mag[31];

endmodule

// File: rtl/fpu_convert.sv
// Sequential int<->float converter, one shift per clock.
// Single-precision, truncating float-to-int.
module fpu_convert
  import fpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  fpu_convert_if.slave bus
);

  conv_state_t state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] o_q, o_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        dir_q, dir_d;
  logic        inv_q, inv_d;
  logic        ov_q, ov_d;
  logic        rdy_q, rdy_d;

  logic [31:0] pack_res;
  logic [31:0] abs_a;
  logic [7:0]  e;
  logic [22:0] f;
  logic [7:0]  d_up, d_dn;
  logic        accept;
  logic        unused_bits;

  assign e      = bus.A[30:23];
  assign f      = bus.A[22:0];
  assign abs_a  = bus.A[31] ? -bus.A : bus.A;
  assign d_up   = e - F2I_ALIGN_EXP;
  assign d_dn   = F2I_ALIGN_EXP - e;
  assign accept = bus.in_valid & rdy_q;
  assign unused_bits = ^{d_up[7:5], d_dn[7:5]};

  fpu_round_pack u_pack (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mag    (mag_q),
    .res    (pack_res)
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    o_d     = o_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dir_d   = dir_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = bus.A[31];
          inv_d  = 1'b0;
          if (bus.opcode == OP_I2F) begin
            mag_d = abs_a;
            exp_d = I2F_EXP_INIT;
            if (bus.A == 32'h0) begin
              o_d     = 32'h0;
              state_d = DONE;
            end else begin
              state_d = abs_a[31] ? ROUND : NORM;
            end
          end else if (e == EXP_MAX && f != 23'h0) begin
            o_d     = INT_MIN;
            inv_d   = 1'b1;
            state_d = DONE;
          end else if (e < EXP_BIAS) begin
            o_d     = 32'h0;
            state_d = DONE;
          end else if (bus.A == F_INT_MIN) begin
            o_d     = INT_MIN;
            state_d = DONE;
          end else if (e >= I2F_EXP_INIT) begin
            o_d     = bus.A[31] ? INT_MIN : INT_MAX;
            inv_d   = 1'b1;
            state_d = DONE;
          end else begin
            mag_d   = {8'b0, 1'b1, f};
            dir_d   = e > F2I_ALIGN_EXP;
            cnt_d   = dir_d ? d_up[4:0] : d_dn[4:0];
            state_d = (cnt_d == 5'd0) ? NEG : ALIGN;
          end
        end
      end
      NORM: begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 8'd1;
        // Look one bit ahead so the normalised cycle is not wasted.
        if (mag_q[30]) state_d = ROUND;
      end
      ROUND: begin
        o_d     = pack_res;
        state_d = DONE;
      end
      ALIGN: begin
        mag_d = dir_q ? (mag_q << 1) : (mag_q >> 1);
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = NEG;
      end
      NEG: begin
        o_d     = sign_q ? -mag_q : mag_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ov_d  = state_d == DONE;
    rdy_d = state_d == IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= 32'h0;
      o_q     <= 32'h0;
      exp_q   <= 8'h0;
      cnt_q   <= 5'h0;
      sign_q  <= 1'b0;
      dir_q   <= 1'b0;
      inv_q   <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      o_q     <= o_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dir_q   <= dir_d;
      inv_q   <= inv_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.O         = o_q;
  assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_fpu_convert.sv
// Directed-vector bench for fpu_convert.
// Table of conversions plus handshake and reset sequences.
module tb_fpu_convert;

  logic clk;
  logic rst;

  fpu_convert_if bus ();

  fpu_convert dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] o;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input logic [31:0] a);
    int w;
    w = 0;
    while (!bus.in_ready && w < 60) begin
      tick();
      w++;
    end
    check("in_ready before send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    tick();
    bus.in_valid = 1'b0;
    bus.opcode   = ~op;
    bus.A        = 32'hDEAD_BEEF;
  endtask

  task automatic wait_out(inout int lat);
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit early);
    int    lat;
    string tag;
    tag = $sformatf("%s %h", v.op ? "F2I" : "I2F", v.a);
    if (early) bus.out_ready = 1'b1;
    send(v.op, v.a);
    lat = 1;
    wait_out(lat);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " O"}, bus.O, v.o);
    check({tag, " invalid"}, 32'(bus.invalid), 32'(v.inv));
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    take();
    check({tag, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.opcode    = 1'b0;
    bus.A         = 32'h0;
    bus.out_ready = 1'b0;
    rst = 1'b1;

    vecs.push_back('{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33});
    vecs.push_back('{1'b0, 32'h4000_0000, 32'h4E80_0000, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 9});
    vecs.push_back('{1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b0, 9});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 25});
    vecs.push_back('{1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 24});
    vecs.push_back('{1'b1, 32'h4B00_0000, 32'h0080_0000, 1'b0, 2});
    vecs.push_back('{1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 9});
    vecs.push_back('{1'b1, 32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 9});
    vecs.push_back('{1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 24});
    vecs.push_back('{1'b1, 32'h3F7F_FFFF, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{1'b1, 32'h7FC0_0000, 32'h8000_0000, 1'b1, 1});
    vecs.push_back('{1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1});
    vecs.push_back('{1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1});
    vecs.push_back('{1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset O", bus.O, 32'h0);
    check("reset invalid", 32'(bus.invalid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // out_ready held high through the whole operation
    v = '{1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 24};
    run_vec(v, 1'b1);

    // operand pulses while busy must be ignored
    send(1'b0, 32'h0000_0001);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      check("busy in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.opcode   = 1'b1;
      bus.A        = 32'h7FC0_0000;
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("stall latency", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
      check("stall O", bus.O, 32'h3F80_0000);
      check("stall invalid", 32'(bus.invalid), 32'd0);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    take();
    check("gap in_ready", 32'(bus.in_ready), 32'd1);
    check("gap out_valid", 32'(bus.out_valid), 32'd0);

    // back-to-back operand right after the gap
    v = '{1'b0, 32'h4000_0000, 32'h4E80_0000, 1'b0, 3};
    run_vec(v, 1'b0);

    // reset in the middle of alignment
    send(1'b1, 32'h3F80_0000);
    repeat (5) tick();
    check("pre-reset out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset O", bus.O, 32'h0);
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("post reset out_valid", 32'(bus.out_valid), 32'd0);
    v = '{1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 24};
    run_vec(v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
